// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between the CPU data path (MAR/MDR side) and the
//   memory responder.
//   addr     word address from MAR (only low ADDR_WIDTH bits are used)
//   wdata    write data from MDRout
//   Read     read request strobe
//   Write    write request strobe
//   Mdatain  registered read data back to the MDR input mux
//   done     one-cycle completion pulse
//   busy     high while a request is in flight
//   err      one-cycle pulse when Read and Write are both raised in IDLE
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             Read;
    logic             Write;
    logic [WIDTH-1:0] Mdatain;
    logic             done;
    logic             busy;
    logic             err;

    modport master (
        output addr, wdata, Read, Write,
        input  Mdatain, done, busy, err
    );

    modport slave (
        input  addr, wdata, Read, Write,
        output Mdatain, done, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU data path. A request (exactly one of
//   Read/Write) is latched in IDLE, waits LATENCY cycles, is performed on an
//   internal word array, and is acknowledged with a one-cycle done pulse.
//   Ports:
//     i_clk   rising-edge clock
//     i_clr   asynchronous active-low reset (array contents are kept)
//     bus     mem_responder_if.slave: addr/wdata/Read/Write in,
//             Mdatain/done/busy/err out (all outputs registered)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic             i_clk,
    input  logic             i_clr,
    mem_responder_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_is_write;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic [WIDTH-1:0]      r_mdatain;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_req;
    logic                  w_conflict;
    logic                  w_access;
    logic                  w_addr_hi_unused;

    // Upper address bits alias onto the array, so they are intentionally dropped.
    assign w_addr_hi_unused = |bus.addr[WIDTH-1:ADDR_WIDTH];

    assign w_req      = (r_state == ST_IDLE) && (bus.Read ^ bus.Write);
    assign w_conflict = (r_state == ST_IDLE) && bus.Read && bus.Write;
    // The access happens on the edge where the wait counter has run out.
    assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = 4'(LATENCY - 1);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_mdatain  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_req) begin
                r_addr     <= bus.addr[ADDR_WIDTH-1:0];
                r_wdata    <= bus.wdata;
                r_is_write <= bus.Write;
            end
            if (w_access && !r_is_write) begin
                r_mdatain <= r_mem[r_addr];
            end
            // Outputs are decoded from the next state so they line up with it.
            r_done <= (w_state_next == ST_DONE);
            r_busy <= (w_state_next != ST_IDLE);
            r_err  <= w_conflict;
        end
    end

    // Word array: no reset, so contents survive i_clr; an aborted request never
    // reaches this point because reset forces the FSM back to IDLE.
    always_ff @(posedge i_clk) begin
        if (w_access && r_is_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus.Mdatain = r_mdatain;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Drives three responders (LATENCY 2, 1 and 15) and checks them against an
//   array model with the expected completion edge taken from LATENCY.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int          lat_exp [3] = '{2, 1, 15};
    logic [31:0] model_mem [int];
    logic [31:0] model_mdata [3];
    int          wq [$];

    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(32)) if0 ();
    mem_responder_if #(.WIDTH(32)) if1 ();
    mem_responder_if #(.WIDTH(32)) if2 ();

    mem_responder #(.WIDTH(32), .ADDR_WIDTH(9), .LATENCY(2))  u_dut0 (.i_clk(clk), .i_clr(clr), .bus(if0));
    mem_responder #(.WIDTH(32), .ADDR_WIDTH(9), .LATENCY(1))  u_dut1 (.i_clk(clk), .i_clr(clr), .bus(if1));
    mem_responder #(.WIDTH(32), .ADDR_WIDTH(9), .LATENCY(15)) u_dut2 (.i_clk(clk), .i_clr(clr), .bus(if2));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        case (d)
            0: begin if0.Read = rd; if0.Write = wr; if0.addr = a; if0.wdata = wd; end
            1: begin if1.Read = rd; if1.Write = wr; if1.addr = a; if1.wdata = wd; end
            default: begin if2.Read = rd; if2.Write = wr; if2.addr = a; if2.wdata = wd; end
        endcase
    endtask

    // {done, busy, err, Mdatain}
    function automatic logic [34:0] get_out(input int d);
        case (d)
            0: return {if0.done, if0.busy, if0.err, if0.Mdatain};
            1: return {if1.done, if1.busy, if1.err, if1.Mdatain};
            default: return {if2.done, if2.busy, if2.err, if2.Mdatain};
        endcase
    endfunction

    // Issue one request at the current negedge; return sampled Mdatain at done
    // and the index of the edge (counted from the sampling edge) that produced it.
    task automatic do_op(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic noise, input logic [31:0] na,
                         output logic [31:0] rd, output int lat);
        logic [34:0] o;
        rd  = '0;
        lat = -1;
        drive(d, ~wr, wr, a, wd);
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (noise) drive(d, 1'b0, 1'b1, na, $urandom);
                else       drive(d, 1'b0, 1'b0, $urandom, $urandom);
                o = get_out(d);
                check_eq("busy_wait", 32'(o[33]), 32'd1);
            end else if (k == 2) begin
                drive(d, 1'b0, 1'b0, $urandom, $urandom);
            end
            o = get_out(d);
            if (o[34]) begin
                lat = k - 1;
                rd  = o[31:0];
                check_eq("err_with_done", 32'(o[32]), 32'd0);
                break;
            end
        end
        @(negedge clk);
        o = get_out(d);
        check_eq("done_pulse", {30'd0, o[34], o[33]}, 32'd0);
    endtask

    task automatic txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic noise, input logic [31:0] na);
        logic [31:0] rd;
        int          lat;
        int          key;
        key = d * 1024 + int'(a % 32'd512);
        do_op(d, wr, a, wd, noise, na, rd, lat);
        check_eq($sformatf("latency%0d", d), 32'(lat), 32'(lat_exp[d]));
        if (wr) begin
            check_eq("mdata_hold", rd, model_mdata[d]);
            model_mem[key] = wd;
        end else begin
            check_eq("rdata", rd, model_mem[key]);
            model_mdata[d] = model_mem[key];
        end
    endtask

    initial begin
        logic [34:0] o;
        logic [31:0] a;
        int          idx;

        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
            model_mdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            o = get_out(d);
            check_eq("reset_flags", {29'd0, o[34:32]}, 32'd0);
            check_eq("reset_mdata", o[31:0], 32'd0);
        end
        clr = 1'b1;
        @(negedge clk);

        // Known value at 0x010, then abort a write to it with reset.
        txn(0, 1'b1, 32'h010, 32'h11112222, 1'b0, 32'd0);
        txn(0, 1'b0, 32'h010, 32'd0, 1'b0, 32'd0);
        drive(0, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        clr = 1'b0;
        #1;
        o = get_out(0);
        check_eq("midreset_flags", {29'd0, o[34:32]}, 32'd0);
        check_eq("midreset_mdata", o[31:0], 32'd0);
        for (int d = 0; d < 3; d++) model_mdata[d] = 32'd0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h010, 32'd0, 1'b0, 32'd0);

        // Write then read back.
        txn(0, 1'b1, 32'h020, 32'h00000005, 1'b0, 32'd0);
        txn(0, 1'b0, 32'h020, 32'd0, 1'b0, 32'd0);

        // Conflicting strobes in IDLE.
        drive(0, 1'b1, 1'b1, 32'h020, 32'hFFFF0000);
        @(posedge clk);
        @(negedge clk);
        o = get_out(0);
        check_eq("conflict_err", 32'(o[32]), 32'd1);
        check_eq("conflict_busy_done", {30'd0, o[34], o[33]}, 32'd0);
        check_eq("conflict_mdata", o[31:0], model_mdata[0]);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        o = get_out(0);
        check_eq("conflict_err_clear", 32'(o[32]), 32'd0);
        txn(0, 1'b0, 32'h020, 32'd0, 1'b0, 32'd0);

        // Write strobe pulsed while a read is waiting must be ignored.
        txn(0, 1'b1, 32'h002, 32'h22222222, 1'b0, 32'd0);
        txn(0, 1'b1, 32'h001, 32'h01010101, 1'b0, 32'd0);
        txn(0, 1'b0, 32'h001, 32'd0, 1'b1, 32'h002);
        txn(0, 1'b0, 32'h002, 32'd0, 1'b0, 32'd0);

        // Address wrap.
        txn(0, 1'b1, 32'h200, 32'hA5A5A5A5, 1'b0, 32'd0);
        txn(0, 1'b0, 32'h000, 32'd0, 1'b0, 32'd0);

        // Randomised traffic, full 32-bit addresses, noise while busy.
        for (int n = 0; n < 60; n++) begin
            if (wq.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = $urandom;
                wq.push_back(int'(a % 32'd512));
                txn(0, 1'b1, a, $urandom, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                idx = wq[$urandom_range(0, wq.size() - 1)];
                a   = 32'($urandom_range(0, 1000) * 512 + idx);
                txn(0, 1'b0, a, 32'd0, 1'($urandom_range(0, 1)), $urandom);
            end
        end

        // Latency extremes.
        for (int d = 1; d < 3; d++) begin
            a = 32'($urandom_range(0, 511));
            txn(d, 1'b1, a, $urandom, 1'b0, 32'd0);
            txn(d, 1'b0, a, 32'd0, 1'b1, a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
